// File: rtl/ps2_key_decoder_pkg.sv
// Key encoding, scan-code constants and decoder state type shared by the
// PS/2 key decoder and anything that consumes its key codes.
package ps2_key_decoder_pkg;

   localparam logic [3:0] key_relesed = 4'd0;
   localparam logic [3:0] key_A       = 4'd1;
   localparam logic [3:0] key_S       = 4'd2;
   localparam logic [3:0] key_W       = 4'd3;
   localparam logic [3:0] key_D       = 4'd4;
   localparam logic [3:0] key_1       = 4'd5;
   localparam logic [3:0] key_2       = 4'd6;
   localparam logic [3:0] key_3       = 4'd7;
   localparam logic [3:0] key_4       = 4'd8;
   localparam logic [3:0] key_esc     = 4'd9;

   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_3     = 8'h26;
   localparam logic [7:0] SC_4     = 8'h25;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BRK     = 2'd1,
      EXT     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_e;

   // key_relesed doubles as the "not a key we care about" result
   function automatic logic [3:0] scan_to_key(input logic [7:0] code);
      case (code)
         SC_A:    return key_A;
         SC_S:    return key_S;
         SC_W:    return key_W;
         SC_D:    return key_D;
         SC_1:    return key_1;
         SC_2:    return key_2;
         SC_3:    return key_3;
         SC_4:    return key_4;
         SC_ESC:  return key_esc;
         default: return key_relesed;
      endcase
   endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 bytes into the currently held key plus change/error strobes.
//
// state   | meaning
// IDLE    | waiting for a make code or a prefix
// BRK     | F0 seen, next byte names the released key
// EXT     | E0 seen, extended key follows (not mapped)
// EXT_BRK | E0 F0 seen, next byte is discarded
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65000,
   parameter int TO_W           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [3:0] key_code,
   output logic       key_event,
   output logic       seq_error
);

   ps2_state_e      state, state_nx;
   logic [TO_W-1:0] cnt, cnt_nx;
   logic [3:0]      key_nx;
   logic            event_nx, error_nx;
   logic [3:0]      mapped;
   logic            is_prefix;

   assign mapped    = scan_to_key(rx_data);
   assign is_prefix = (rx_data == SC_BREAK) || (rx_data == SC_EXT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         key_code  <= key_relesed;
         key_event <= 1'b0;
         seq_error <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         key_code  <= key_nx;
         key_event <= event_nx;
         seq_error <= error_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      key_nx   = key_code;
      event_nx = 1'b0;
      error_nx = 1'b0;

      if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == SC_BREAK) begin
                  state_nx = BRK;
               end else if (rx_data == SC_EXT) begin
                  state_nx = EXT;
               end else if (mapped != key_relesed && mapped != key_code) begin
                  key_nx   = mapped;
                  event_nx = 1'b1;
               end
            end
            BRK: begin
               state_nx = IDLE;
               if (is_prefix) begin
                  error_nx = 1'b1;
               end else if (mapped != key_relesed && mapped == key_code) begin
                  // only the held key can clear the output; last press wins
                  key_nx   = key_relesed;
                  event_nx = 1'b1;
               end
            end
            EXT: begin
               state_nx = (rx_data == SC_BREAK) ? EXT_BRK : IDLE;
               error_nx = (rx_data == SC_EXT);
            end
            EXT_BRK: begin
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end else if (state != IDLE) begin
         if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx = IDLE;
            error_nx = 1'b1;
         end else begin
            cnt_nx = cnt + TO_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: stimulus queues expected strobes,
// a negedge monitor pops and compares every key_event / seq_error it sees.
module tb_ps2_key_decoder;
   import ps2_key_decoder_pkg::*;

   localparam int TO = 16;

   typedef struct {
      logic       err;
      logic [3:0] code;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [3:0] key_code;
   logic       key_event;
   logic       seq_error;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .key_code(key_code), .key_event(key_event), .seq_error(seq_error)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (key_event || seq_error) begin
         exp_t e;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: got event=%0b err=%0b code=%0d, required none",
                     key_event, seq_error, key_code);
         end else begin
            e = exp_q.pop_front();
            if (seq_error !== e.err || key_event !== !e.err ||
                (!e.err && key_code !== e.code) || (e.cyc >= 0 && cyc != e.cyc)) begin
               fails++;
               $display("FAIL strobe: got event=%0b err=%0b code=%0d cyc=%0d, required err=%0b code=%0d cyc=%0d",
                        key_event, seq_error, key_code, cyc, e.err, e.code, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic expect_key(input logic [3:0] code);
      exp_t e;
      e.err = 1'b0; e.code = code; e.cyc = -1;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      check("reset_key_code", int'(key_code), int'(key_relesed));
      check("reset_event", int'(key_event), 0);
      check("reset_error", int'(seq_error), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", int'(dut.state), int'(IDLE));

      // press and release A
      expect_key(key_A);   send(8'h1C);
      check("a_held", int'(key_code), 1);
      send(8'hF0);
      expect_key(key_relesed); send(8'h1C);
      check("a_released", int'(key_code), 0);

      // typematic W, then D, then release of non-held W
      expect_key(key_W);
      send(8'h1D); send(8'h1D); send(8'h1D);
      expect_key(key_D);   send(8'h23);
      send(8'hF0); send(8'h1D);
      check("d_still_held", int'(key_code), int'(key_D));

      // extended sequences interleaved with ESC
      send(8'hE0); send(8'h75);
      expect_key(key_esc); send(8'h76);
      send(8'hE0); send(8'hF0); send(8'h75);
      check("esc_held", int'(key_code), 9);
      check("ext_state_idle", int'(dut.state), int'(IDLE));

      // prefix timeout
      send(8'hF0);
      e.err = 1'b1; e.code = key_esc; e.cyc = cyc + TO;
      exp_q.push_back(e);
      repeat (TO + 4) @(negedge clk);
      check("timeout_state", int'(dut.state), int'(IDLE));
      check("timeout_key_kept", int'(key_code), int'(key_esc));
      expect_key(key_S);   send(8'h1B);

      // double break prefix, then unmapped Enter
      send(8'hF0);
      e.err = 1'b1; e.code = key_S; e.cyc = -1;
      exp_q.push_back(e);
      send(8'hF0);
      check("dbl_prefix_state", int'(dut.state), int'(IDLE));
      send(8'h5A);
      check("enter_ignored", int'(key_code), int'(key_S));

      // double extended prefix
      send(8'hE0);
      exp_q.push_back(e);
      send(8'hE0);
      check("dbl_ext_state", int'(dut.state), int'(IDLE));

      // reset mid-sequence
      expect_key(key_1);   send(8'h16);
      send(8'hF0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midseq_reset_key", int'(key_code), 0);
      check("midseq_reset_state", int'(dut.state), int'(IDLE));
      expect_key(key_1);   send(8'h16);
      check("after_reset_key", int'(key_code), int'(key_1));

      repeat (5) @(negedge clk);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
